// File: rtl/yarc_pkg.sv
// Shared core-wide defaults for the yarc pipeline.
// Holds only constants; no logic, no latency, no backpressure.
// Imported by the decode-stage register file and its helpers.
package yarc_pkg;
    localparam int XLEN_DEFAULT = 32;
    localparam int NREG_DEFAULT = 32;
endpackage

// File: rtl/sb_counter.sv
// Per-register pending-write counter, saturating at 0 and MAXPEND.
// Latency: cnt updates one cycle after inc/dec; eff and flags are combinational.
// Backpressure: none here; the caller must gate inc when eff == MAXPEND.
module sb_counter #(
    parameter int MAXPEND = 3,
    parameter int CW      = $clog2(MAXPEND + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec_a,
    input  logic          dec_b,
    output logic [CW-1:0] cnt,
    output logic [CW-1:0] eff,
    output logic          underflow,
    output logic          overflow
);
    logic [1:0]    dec_n;
    logic [CW+1:0] cnt_x;
    logic [CW+1:0] dec_x;
    logic [CW+1:0] after_dec;
    logic [CW-1:0] cnt_nxt;

    assign dec_n = {1'b0, dec_a} + {1'b0, dec_b};
    assign cnt_x = {2'b00, cnt};
    assign dec_x = {{CW{1'b0}}, dec_n};

    // Decrements are applied before the increment: a same-cycle issue never
    // absorbs a stray writeback for a register that had nothing in flight.
    assign underflow = dec_x > cnt_x;
    assign after_dec = underflow ? '0 : (cnt_x - dec_x);
    assign eff       = after_dec[CW-1:0];
    assign overflow  = inc && (after_dec == (CW+2)'(MAXPEND));
    assign cnt_nxt   = (inc && !overflow) ? (after_dec[CW-1:0] + 1'b1) : after_dec[CW-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end
endmodule

// File: rtl/regfile_sb.sv
// Register file with registered, write-first read ports and a pending-write scoreboard.
// Latency: read data 1 cycle after rd_en; issue decision combinational in the same cycle.
// Backpressure: iss_ready drops on a source hazard or a saturated destination counter.
module regfile_sb
    import yarc_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int NREG    = NREG_DEFAULT,
    parameter int NRD     = 2,
    parameter int MAXPEND = 3,
    parameter int AW      = $clog2(NREG),
    parameter int CW      = $clog2(MAXPEND + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic              wb_valid,
    input  logic [AW-1:0]     wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              iss_valid,
    input  logic              iss_we,
    input  logic [AW-1:0]     iss_rd,
    input  logic [NRD-1:0]    iss_src_used,
    output logic              iss_ready,
    input  logic              kill_valid,
    input  logic [AW-1:0]     kill_rd,
    output logic              busy,
    output logic              err
);
    logic [XLEN-1:0] regs [NREG];
    logic [CW-1:0]   pend [NREG];
    logic [CW-1:0]   eff  [NREG];
    logic [NREG-1:0] uf;
    logic [NREG-1:0] ovf;
    logic [NRD-1:0]  src_haz;
    logic            wb_hit;
    logic            dst_sat;
    logic            iss_fire;

    assign wb_hit   = wb_valid && (wb_rd != '0);
    assign iss_fire = iss_valid && iss_ready && iss_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else if (wb_hit) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Register 0 has no counter; it is never pending.
    assign pend[0] = '0;
    assign eff[0]  = '0;
    assign uf[0]   = 1'b0;
    assign ovf[0]  = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_sb
        sb_counter #(
            .MAXPEND (MAXPEND),
            .CW      (CW)
        ) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (iss_fire && (iss_rd == AW'(r))),
            .dec_a     (wb_valid && (wb_rd == AW'(r))),
            .dec_b     (kill_valid && (kill_rd == AW'(r))),
            .cnt       (pend[r]),
            .eff       (eff[r]),
            .underflow (uf[r]),
            .overflow  (ovf[r])
        );
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] rd_q;

        assign addr = rd_addr[i*AW +: AW];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rd_q <= '0;
            end else if (rd_en) begin
                if (addr == '0) begin
                    rd_q <= '0;
                end else if (wb_hit && (wb_rd == addr)) begin
                    rd_q <= wb_data;
                end else begin
                    rd_q <= regs[addr];
                end
            end
        end

        assign rd_data[i*XLEN +: XLEN] = rd_q;
        assign src_haz[i] = iss_src_used[i] && (addr != '0) && (eff[addr] != '0);
    end

    assign dst_sat   = iss_we && (iss_rd != '0) && (eff[iss_rd] == CW'(MAXPEND));
    assign iss_ready = !(|src_haz) && !dst_sat;

    always_comb begin
        busy = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            busy = busy | (pend[r] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if ((|uf) || (|ovf)) begin
            err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios plus randomized traffic against a
// behavioural model built from register values and in-flight write counts.
module tb_regfile_sb;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int MAXP = 3;
    localparam int AW   = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              rd_en = 1'b0;
    logic [NRD*AW-1:0] rd_addr = '0;
    logic [NRD*XLEN-1:0] rd_data;
    logic              wb_valid = 1'b0;
    logic [AW-1:0]     wb_rd = '0;
    logic [XLEN-1:0]   wb_data = '0;
    logic              iss_valid = 1'b0;
    logic              iss_we = 1'b0;
    logic [AW-1:0]     iss_rd = '0;
    logic [NRD-1:0]    iss_src_used = '0;
    logic              iss_ready;
    logic              kill_valid = 1'b0;
    logic [AW-1:0]     kill_rd = '0;
    logic              busy;
    logic              err;

    int errors = 0;
    int checks = 0;

    logic [XLEN-1:0] m_regs [NREG];
    int              m_pend [NREG];
    logic [XLEN-1:0] m_rd   [NRD];
    bit              m_err;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .MAXPEND(MAXP)) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .iss_valid    (iss_valid),
        .iss_we       (iss_we),
        .iss_rd       (iss_rd),
        .iss_src_used (iss_src_used),
        .iss_ready    (iss_ready),
        .kill_valid   (kill_valid),
        .kill_rd      (kill_rd),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    function automatic int m_eff(input int r);
        int e;
        e = m_pend[r];
        if (wb_valid && int'(wb_rd) == r) e = e - 1;
        if (kill_valid && int'(kill_rd) == r) e = e - 1;
        return (e < 0) ? 0 : e;
    endfunction

    function automatic bit m_ready();
        bit ok;
        int a;
        ok = 1'b1;
        for (int i = 0; i < NRD; i++) begin
            a = int'(rd_addr[i*AW +: AW]);
            if (iss_src_used[i] && a != 0 && m_eff(a) != 0) ok = 1'b0;
        end
        if (iss_we && iss_rd != 0 && m_eff(int'(iss_rd)) == MAXP) ok = 1'b0;
        return ok;
    endfunction

    function automatic bit m_busy();
        bit b;
        b = 1'b0;
        for (int r = 1; r < NREG; r++) if (m_pend[r] != 0) b = 1'b1;
        return b;
    endfunction

    task automatic clear_inputs();
        rd_en = 0; rd_addr = '0; wb_valid = 0; wb_rd = '0; wb_data = '0;
        iss_valid = 0; iss_we = 0; iss_rd = '0; iss_src_used = '0;
        kill_valid = 0; kill_rd = '0;
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            m_regs[r] = '0;
            m_pend[r] = 0;
        end
        for (int i = 0; i < NRD; i++) m_rd[i] = '0;
        m_err = 1'b0;
    endtask

    // Advance one clock: the model consumes the inputs currently applied.
    task automatic tick();
        logic [XLEN-1:0] nregs [NREG];
        int npend [NREG];
        logic [XLEN-1:0] nrd [NRD];
        bit nerr;
        bit rdy;
        int decs;
        int a;
        rdy = m_ready();
        nerr = m_err;
        for (int r = 0; r < NREG; r++) begin
            nregs[r] = m_regs[r];
            npend[r] = m_pend[r];
        end
        for (int i = 0; i < NRD; i++) nrd[i] = m_rd[i];
        if (wb_valid && wb_rd != 0) nregs[wb_rd] = wb_data;
        if (rd_en) begin
            for (int i = 0; i < NRD; i++) begin
                a = int'(rd_addr[i*AW +: AW]);
                nrd[i] = (a == 0) ? '0 : nregs[a];
            end
        end
        for (int r = 1; r < NREG; r++) begin
            decs = 0;
            if (wb_valid && int'(wb_rd) == r) decs++;
            if (kill_valid && int'(kill_rd) == r) decs++;
            if (decs > npend[r]) begin
                nerr = 1'b1;
                npend[r] = 0;
            end else begin
                npend[r] = npend[r] - decs;
            end
            if (iss_valid && rdy && iss_we && int'(iss_rd) == r) npend[r]++;
        end
        @(posedge clk);
        #1;
        for (int r = 0; r < NREG; r++) begin
            m_regs[r] = nregs[r];
            m_pend[r] = npend[r];
        end
        for (int i = 0; i < NRD; i++) m_rd[i] = nrd[i];
        m_err = nerr;
    endtask

    task automatic do_reset();
        clear_inputs();
        #2 rst = 1'b0;
        model_reset();
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
        checks++;
        if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_flags busy=%b err=%b exp=0,0", busy, err); end
        rd_en = 1; rd_addr = {5'd0, 5'd5};
        iss_valid = 1; iss_src_used = 2'b11;
        #1;
        checks++;
        if (iss_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", iss_ready); end
        tick();
        clear_inputs();
        checks++;
        if (rd_data !== '0) begin errors++; $display("FAIL reset_read_x5_x0 got=%h exp=0", rd_data); end
    endtask

    task automatic test_raw_hazard();
        iss_valid = 1; iss_we = 1; iss_rd = 5;
        tick();
        clear_inputs();
        iss_valid = 1; rd_addr = {5'd0, 5'd5}; iss_src_used = 2'b01;
        #1;
        checks++;
        if (iss_ready !== 1'b0) begin errors++; $display("FAIL raw_stall got=%b exp=0", iss_ready); end
        tick();
        wb_valid = 1; wb_rd = 5; wb_data = 32'hDEADBEEF; rd_en = 1;
        #1;
        checks++;
        if (iss_ready !== 1'b1) begin errors++; $display("FAIL raw_wb_clears got=%b exp=1", iss_ready); end
        tick();
        clear_inputs();
        checks++;
        if (rd_data[XLEN-1:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL raw_bypass got=%h exp=deadbeef", rd_data[XLEN-1:0]); end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < MAXP; k++) begin
            iss_valid = 1; iss_we = 1; iss_rd = 7;
            tick();
        end
        #1;
        checks++;
        if (iss_ready !== 1'b0) begin errors++; $display("FAIL sat_stall got=%b exp=0", iss_ready); end
        kill_valid = 1; kill_rd = 7;
        #1;
        checks++;
        if (iss_ready !== 1'b1) begin errors++; $display("FAIL sat_kill_accept got=%b exp=1", iss_ready); end
        tick();
        kill_valid = 0;
        #1;
        checks++;
        if (iss_ready !== 1'b0 || m_pend[7] != MAXP) begin errors++; $display("FAIL sat_still_full ready=%b exp=0", iss_ready); end
        clear_inputs();
        for (int k = 0; k < MAXP; k++) begin
            kill_valid = 1; kill_rd = 7;
            tick();
        end
        clear_inputs();
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL sat_err got=%b exp=0", err); end
    endtask

    task automatic test_same_cycle();
        for (int k = 0; k < 2; k++) begin
            iss_valid = 1; iss_we = 1; iss_rd = 9;
            tick();
        end
        wb_valid = 1; wb_rd = 9; wb_data = 32'h0000_0099; kill_valid = 1; kill_rd = 9;
        tick();
        clear_inputs();
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL same_cycle_flags err=%b busy=%b exp=0,1", err, busy); end
        iss_valid = 1; rd_addr = {5'd9, 5'd0}; iss_src_used = 2'b10;
        #1;
        checks++;
        if (iss_ready !== 1'b0) begin errors++; $display("FAIL same_cycle_pend1 got=%b exp=0", iss_ready); end
        kill_valid = 1; kill_rd = 9;
        tick();
        kill_valid = 0;
        #1;
        checks++;
        if (iss_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL same_cycle_cleared ready=%b busy=%b exp=1,0", iss_ready, busy); end
        clear_inputs();
    endtask

    task automatic test_x0();
        iss_valid = 1; iss_we = 1; iss_rd = 0;
        #1;
        checks++;
        if (iss_ready !== 1'b1) begin errors++; $display("FAIL x0_writer got=%b exp=1", iss_ready); end
        tick();
        clear_inputs();
        iss_valid = 1; rd_addr = {5'd0, 5'd0}; iss_src_used = 2'b11;
        #1;
        checks++;
        if (iss_ready !== 1'b1) begin errors++; $display("FAIL x0_reader got=%b exp=1", iss_ready); end
        wb_valid = 1; wb_rd = 0; wb_data = 32'hFFFFFFFF; rd_en = 1;
        tick();
        clear_inputs();
        rd_en = 1;
        tick();
        clear_inputs();
        checks++;
        if (rd_data !== '0 || busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL x0_reads_zero rd=%h busy=%b err=%b exp=0,0,0", rd_data, busy, err); end
    endtask

    task automatic test_random();
        logic [XLEN-1:0] exp_rd;
        for (int n = 0; n < 400; n++) begin
            rd_en        = 1'($urandom_range(0, 1));
            rd_addr      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            iss_valid    = 1'($urandom_range(0, 1));
            iss_we       = 1'($urandom_range(0, 1));
            iss_rd       = 5'($urandom_range(0, 7));
            iss_src_used = 2'($urandom_range(0, 3));
            wb_valid     = ($urandom_range(0, 3) == 0);
            wb_rd        = 5'($urandom_range(0, 7));
            wb_data      = $urandom;
            kill_valid   = ($urandom_range(0, 7) == 0);
            kill_rd      = 5'($urandom_range(0, 7));
            #1;
            checks++;
            if (iss_ready !== m_ready()) begin errors++; $display("FAIL rand_ready n=%0d got=%b exp=%b", n, iss_ready, m_ready()); end
            tick();
            for (int i = 0; i < NRD; i++) begin
                exp_rd = m_rd[i];
                checks++;
                if (rd_data[i*XLEN +: XLEN] !== exp_rd) begin errors++; $display("FAIL rand_rd%0d n=%0d got=%h exp=%h", i, n, rd_data[i*XLEN +: XLEN], exp_rd); end
            end
            checks++;
            if (busy !== m_busy() || err !== m_err) begin errors++; $display("FAIL rand_flags n=%0d busy=%b/%b err=%b/%b", n, busy, m_busy(), err, m_err); end
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_and_underflow();
        iss_valid = 1; iss_we = 1; iss_rd = 12;
        tick();
        clear_inputs();
        do_reset();
        checks++;
        if (busy !== 1'b0 || err !== 1'b0 || rd_data !== '0) begin errors++; $display("FAIL mid_reset busy=%b err=%b rd=%h exp=0", busy, err, rd_data); end
        wb_valid = 1; wb_rd = 4; wb_data = 32'h1234_5678;
        tick();
        clear_inputs();
        rd_en = 1; rd_addr = {5'd4, 5'd0};
        tick();
        clear_inputs();
        checks++;
        if (err !== 1'b1 || rd_data[2*XLEN-1:XLEN] !== 32'h1234_5678) begin errors++; $display("FAIL underflow err=%b x4=%h exp=1,12345678", err, rd_data[2*XLEN-1:XLEN]); end
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", err); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_raw_hazard();
        test_saturation();
        test_same_cycle();
        test_x0();
        test_random();
        test_reset_mid_and_underflow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
